mem_port_arbiter: RTL and testbench

Arbitrates one synchronous single-port SRAM between the instruction-fetch requester (IF stage) and the data requester (EX stage load/store). The pipeline can then run on a unified memory instead of split inst/data SRAMs. Each requester uses a req/addr_ok/data_ok handshake. The arbiter tracks the single in-flight response and routes it back to its owner. Data has priority by default, and a starvation counter bounds how long fetch can be locked out.

---
 rtl/mem_port_arbiter.sv | 103 ++++++++++
 tb/tb_mem_port_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one single-port SRAM between the fetch and data requesters
//            with a one-deep response tracker. Define ARB_RR_EN for round-robin
//            conflict resolution instead of data priority with starvation bound.
// Revision : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [31:0]       inst_rdata,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [3:0]        data_wstrb,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [31:0]       data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [31:0]       data_rdata,
    output logic              sram_en,
    output logic [3:0]        sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata,
    output logic [3:0]        starve_cnt
);

    logic w_inst_wins;
    logic w_grant_inst;
    logic w_grant_data;
    logic r_resp_inst;
    logic r_resp_data;

    // Grants are gated by resetn so nothing reaches the SRAM while in reset.
    assign w_grant_inst = resetn & inst_req & (~data_req | w_inst_wins);
    assign w_grant_data = resetn & data_req & (~inst_req | ~w_inst_wins);

`ifdef ARB_RR_EN
    logic r_last_grant;     // 1: inst was granted last, 0: data was

    assign w_inst_wins = ~r_last_grant;
    assign starve_cnt  = 4'd0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_last_grant <= 1'b0;
        end else if (w_grant_inst) begin
            r_last_grant <= 1'b1;
        end else if (w_grant_data) begin
            r_last_grant <= 1'b0;
        end
    end
`else
    localparam logic [3:0] c_starve_max = 4'(STARVE_MAX);

    logic [3:0] r_starve_cnt;

    assign w_inst_wins = (r_starve_cnt == c_starve_max);
    assign starve_cnt  = r_starve_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_starve_cnt <= 4'd0;
        end else if (!inst_req || w_grant_inst) begin
            r_starve_cnt <= 4'd0;
        end else if (w_grant_data && (r_starve_cnt != c_starve_max)) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_resp_inst <= 1'b0;
            r_resp_data <= 1'b0;
        end else begin
            r_resp_inst <= w_grant_inst;
            r_resp_data <= w_grant_data;
        end
    end

    assign inst_addr_ok = w_grant_inst;
    assign data_addr_ok = w_grant_data;
    assign inst_data_ok = r_resp_inst;
    assign data_data_ok = r_resp_data;
    assign inst_rdata   = sram_rdata;
    assign data_rdata   = sram_rdata;

    assign sram_en    = w_grant_inst | w_grant_data;
    assign sram_we    = (w_grant_data & data_wr) ? data_wstrb : 4'b0000;
    assign sram_addr  = w_grant_inst ? inst_addr : data_addr;
    assign sram_wdata = data_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Directed bench with SRAM model, cycle-level reference model and
//            literal expectations for mem_port_arbiter (honours ARB_RR_EN).
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int P_STARVE = 4;
`ifdef ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req, data_req, data_wr;
    logic [31:0] inst_addr, data_addr, data_wdata;
    logic [3:0]  data_wstrb;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        sram_en;
    logic [3:0]  sram_we;
    logic [31:0] sram_addr, sram_wdata;
    logic [31:0] sram_rdata = 32'h0;
    logic [3:0]  starve_cnt;

    always #5 clk = ~clk;

    mem_port_arbiter #(.STARVE_MAX(P_STARVE), .ADDR_W(32)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .starve_cnt(starve_cnt)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // SRAM model, driven only by the DUT's sram_* outputs.
    logic [31:0] sram_mem [logic [31:0]];
    logic [31:0] gold_mem [logic [31:0]];

    always @(posedge clk) begin
        if (sram_en) begin
            sram_rdata <= sram_mem.exists(sram_addr) ? sram_mem[sram_addr] : 32'h0;
            for (int b = 0; b < 4; b++) begin
                if (sram_we[b]) begin
                    if (!sram_mem.exists(sram_addr)) sram_mem[sram_addr] = 32'h0;
                    sram_mem[sram_addr][8*b +: 8] = sram_wdata[8*b +: 8];
                end
            end
        end
    end

    // Reference model state: who owns the next response and its expected data.
    bit          run = 1'b0;
    bit          rec = 1'b0;
    int          m_pend = 0;          // 0 none, 1 inst, 2 data
    logic [31:0] m_exp;
    bit          m_exp_v;
    int          m_denied = 0;
    bit          m_last_inst = 1'b0;
    logic [31:0] last_inst_rdata = 32'h0;
    logic [31:0] last_data_rdata = 32'h0;
    byte         rec_g[$];
    int          rec_s[$];

    always @(negedge clk) begin
        bit          gi, gd;
        logic [31:0] w;
        if (run) begin
            if (!resetn) begin
                chk("rst_inst_addr_ok", {31'b0, inst_addr_ok}, 32'd0);
                chk("rst_data_addr_ok", {31'b0, data_addr_ok}, 32'd0);
                chk("rst_inst_data_ok", {31'b0, inst_data_ok}, 32'd0);
                chk("rst_data_data_ok", {31'b0, data_data_ok}, 32'd0);
                chk("rst_sram_en", {31'b0, sram_en}, 32'd0);
                chk("rst_sram_we", {28'b0, sram_we}, 32'd0);
                chk("rst_starve_cnt", {28'b0, starve_cnt}, 32'd0);
                m_pend = 0; m_denied = 0; m_last_inst = 1'b0;
            end else begin
                chk("inst_data_ok", {31'b0, inst_data_ok}, {31'b0, m_pend == 1});
                chk("data_data_ok", {31'b0, data_data_ok}, {31'b0, m_pend == 2});
                chk("data_ok_overlap", {31'b0, inst_data_ok & data_data_ok}, 32'd0);
                if (m_pend == 1) chk("inst_rdata", inst_rdata, m_exp);
                if (m_pend == 2 && m_exp_v) chk("data_rdata", data_rdata, m_exp);
                if (inst_data_ok) last_inst_rdata = inst_rdata;
                if (data_data_ok) last_data_rdata = data_rdata;

                gi = inst_req && (!data_req || (RR ? !m_last_inst : (m_denied == P_STARVE)));
                gd = data_req && !gi;
                chk("inst_addr_ok", {31'b0, inst_addr_ok}, {31'b0, gi});
                chk("data_addr_ok", {31'b0, data_addr_ok}, {31'b0, gd});
                chk("sram_en", {31'b0, sram_en}, {31'b0, gi | gd});
                chk("sram_we", {28'b0, sram_we}, (gd && data_wr) ? {28'b0, data_wstrb} : 32'd0);
                if (gi) chk("sram_addr_inst", sram_addr, inst_addr);
                if (gd) chk("sram_addr_data", sram_addr, data_addr);
                if (gd && data_wr) chk("sram_wdata", sram_wdata, data_wdata);
                chk("starve_cnt", {28'b0, starve_cnt}, RR ? 32'd0 : 32'(m_denied));
                if (rec) begin
                    rec_g.push_back(inst_addr_ok ? 8'h49 : (data_addr_ok ? 8'h44 : 8'h2D));
                    rec_s.push_back(int'(starve_cnt));
                end

                if (gi) begin
                    m_pend = 1; m_exp_v = 1'b1;
                    m_exp = gold_mem.exists(inst_addr) ? gold_mem[inst_addr] : 32'h0;
                end else if (gd) begin
                    m_pend = 2; m_exp_v = !data_wr;
                    m_exp = gold_mem.exists(data_addr) ? gold_mem[data_addr] : 32'h0;
                    if (data_wr) begin
                        w = m_exp;
                        for (int b = 0; b < 4; b++)
                            if (data_wstrb[b]) w[8*b +: 8] = data_wdata[8*b +: 8];
                        gold_mem[data_addr] = w;
                    end
                end else begin
                    m_pend = 0;
                end
                m_denied = (inst_req && gd) ? ((m_denied < P_STARVE) ? m_denied + 1 : P_STARVE) : 0;
                if (gi) m_last_inst = 1'b1;
                else if (gd) m_last_inst = 1'b0;
            end
        end
    end

    task automatic drive(input bit ir, input logic [31:0] ia, input bit dr, input bit dw,
                         input logic [3:0] ws, input logic [31:0] da, input logic [31:0] dd);
        @(posedge clk);
        #1;
        inst_req = ir; inst_addr = ia;
        data_req = dr; data_wr = dw; data_wstrb = ws; data_addr = da; data_wdata = dd;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic fetch(input logic [31:0] a);
        drive(1'b1, a, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic load(input logic [31:0] a);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, a, 32'h0);
    endtask

    initial begin
        string exp_g;
        int    exp_s [10];
        resetn = 1'b0;
        inst_req = 1'b0; inst_addr = 32'h0;
        data_req = 1'b0; data_wr = 1'b0; data_wstrb = 4'h0; data_addr = 32'h0; data_wdata = 32'h0;
        sram_mem[32'h1C000000] = 32'h02800404;  gold_mem[32'h1C000000] = 32'h02800404;
        sram_mem[32'h00000100] = 32'h11223344;  gold_mem[32'h00000100] = 32'h11223344;
        run = 1'b1;

        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        idle();

        fetch(32'h1C000000);
        idle(); idle();
        chk("lit_single_fetch_rdata", last_inst_rdata, 32'h02800404);

        drive(1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h100, 32'hAABBCCDD);
        load(32'h100);
        idle(); idle();
        chk("lit_store_load_rdata", last_data_rdata, 32'h1122CCDD);

        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'h1C000000, 1'b1, 1'b0, 4'h0, 32'h100, 32'h0);
            rec = 1'b1;
        end
        idle();
        rec = 1'b0;
        if (RR) begin
            exp_g = "IDIDIDIDID";
            exp_s = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        end else begin
            exp_g = "DDDDIDDDDI";
            exp_s = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4};
        end
        chk("lit_conflict_len", 32'(rec_g.size()), 32'd10);
        for (int i = 0; i < 10 && i < rec_g.size(); i++) begin
            chk($sformatf("lit_conflict_grant[%0d]", i), {24'b0, rec_g[i]}, {24'b0, exp_g[i]});
            chk($sformatf("lit_conflict_starve[%0d]", i), 32'(rec_s[i]), 32'(exp_s[i]));
        end

        // Ownership switch: data at T, inst at T+1.
        load(32'h100);
        fetch(32'h1C000000);
        idle(); idle();

        // Reset one cycle after a data grant drops the pending response.
        load(32'h100);
        idle();
        resetn = 1'b0;
        idle(); idle();
        resetn = 1'b1;
        idle();
        fetch(32'h1C000000);
        idle(); idle();

        run = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
